// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and screen geometry for the tank shell logic
package tank_pkg;

    typedef enum logic [1:0] {IDLE, FLY, BOOM} shell_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/shell_ctrl_if.sv
// rtl/shell_ctrl_if.sv - game-side signal bundle between tank logic and the shell controller
interface shell_ctrl_if;

    logic        frame_tick;
    logic [7:0]  keycode;
    logic [9:0]  TankX;
    logic [9:0]  TankY;
    logic [1:0]  tank_dir;
    logic [9:0]  OppX;
    logic [9:0]  OppY;
    logic [9:0]  ShellX;
    logic [9:0]  ShellY;
    logic        shell_active;
    logic        exploding;
    logic        hit;
    logic [3:0]  score;

    modport master (
        output frame_tick, keycode, TankX, TankY, tank_dir, OppX, OppY,
        input  ShellX, ShellY, shell_active, exploding, hit, score
    );

    modport slave (
        input  frame_tick, keycode, TankX, TankY, tank_dir, OppX, OppY,
        output ShellX, ShellY, shell_active, exploding, hit, score
    );

endinterface

// File: rtl/key_edge.sv
// rtl/key_edge.sv - registered key-match level with a press-edge pulse
module key_edge #(
    parameter logic [7:0] CODE = 8'h2C
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       rise
);

    logic match;
    logic level;

    assign match = (keycode == CODE);

    always_ff @(posedge Clk) begin
        if (Reset) level <= 1'b0;
        else       level <= match;
    end

    assign rise = match & ~level;

endmodule

// File: rtl/shell_ctrl.sv
// rtl/shell_ctrl.sv - single-shell fire/fly/explode controller with hit scoring
module shell_ctrl
    import tank_pkg::*;
#(
    parameter logic [7:0] FIRE_CODE      = 8'h2C,
    parameter int         SHELL_SPEED    = 4,
    parameter int         EXPLODE_FRAMES = 16,
    parameter int         HIT_HALF       = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    shell_ctrl_if.slave  bus
);

    localparam int          CW    = (EXPLODE_FRAMES > 2) ? $clog2(EXPLODE_FRAMES) : 1;
    localparam logic [10:0] SPD   = 11'(SHELL_SPEED);
    localparam logic [10:0] HALF  = 11'(HIT_HALF);
    localparam logic [10:0] MAX_X = 11'(SCREEN_W);
    localparam logic [10:0] MAX_Y = 11'(SCREEN_H);
    localparam logic [CW-1:0] CNT_LOAD = CW'(EXPLODE_FRAMES - 1);

    shell_state_t state, state_n;
    dir_t         dir_q, dir_n;
    logic [9:0]   shell_x, shell_y, x_n, y_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]   score_q, score_n;
    logic         hit_q, hit_n;
    logic         active_q, boom_q;
    logic         fire_req, fire_edge, pending;
    logic [10:0]  nx, ny;
    logic         oob, hit_now;

    key_edge #(.CODE(FIRE_CODE)) u_key_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (bus.keycode),
        .rise    (fire_edge)
    );

    // An edge arriving on the tick itself counts toward that tick.
    assign pending = fire_req | fire_edge;

    always_ff @(posedge Clk) begin
        if (Reset)               fire_req <= 1'b0;
        else if (bus.frame_tick) fire_req <= 1'b0;
        else if (fire_edge)      fire_req <= 1'b1;
    end

    // Candidate position on the latched axis, 11 bits so underflow/overflow are visible.
    always_comb begin
        nx  = {1'b0, shell_x};
        ny  = {1'b0, shell_y};
        oob = 1'b0;
        case (dir_q)
            DIR_UP: begin
                ny  = {1'b0, shell_y} - SPD;
                oob = ({1'b0, shell_y} < SPD);
            end
            DIR_RIGHT: begin
                nx  = {1'b0, shell_x} + SPD;
                oob = (nx >= MAX_X);
            end
            DIR_DOWN: begin
                ny  = {1'b0, shell_y} + SPD;
                oob = (ny >= MAX_Y);
            end
            default: begin
                nx  = {1'b0, shell_x} - SPD;
                oob = ({1'b0, shell_x} < SPD);
            end
        endcase
        hit_now = (abs_diff(nx, {1'b0, bus.OppX}) <= HALF) &&
                  (abs_diff(ny, {1'b0, bus.OppY}) <= HALF);
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        x_n     = shell_x;
        y_n     = shell_y;
        cnt_n   = cnt;
        score_n = score_q;
        hit_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_tick && pending) begin
                    x_n     = bus.TankX;
                    y_n     = bus.TankY;
                    dir_n   = dir_t'(bus.tank_dir);
                    state_n = FLY;
                end
            end
            FLY: begin
                if (bus.frame_tick) begin
                    if (oob) begin
                        state_n = IDLE;
                    end else begin
                        x_n = nx[9:0];
                        y_n = ny[9:0];
                        if (hit_now) begin
                            state_n = BOOM;
                            cnt_n   = CNT_LOAD;
                            hit_n   = 1'b1;
                            if (score_q != 4'd15) score_n = score_q + 4'd1;
                        end
                    end
                end
            end
            BOOM: begin
                if (bus.frame_tick) begin
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            dir_q    <= DIR_UP;
            shell_x  <= '0;
            shell_y  <= '0;
            cnt      <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            active_q <= 1'b0;
            boom_q   <= 1'b0;
        end else begin
            state    <= state_n;
            dir_q    <= dir_n;
            shell_x  <= x_n;
            shell_y  <= y_n;
            cnt      <= cnt_n;
            score_q  <= score_n;
            hit_q    <= hit_n;
            active_q <= (state_n == FLY);
            boom_q   <= (state_n == BOOM);
        end
    end

    assign bus.ShellX       = shell_x;
    assign bus.ShellY       = shell_y;
    assign bus.shell_active = active_q;
    assign bus.exploding    = boom_q;
    assign bus.hit          = hit_q;
    assign bus.score        = score_q;

endmodule

// File: tb/tb_shell_ctrl.sv
// tb/tb_shell_ctrl.sv - directed vector and sequence checks for shell_ctrl
module tb_shell_ctrl;

    localparam logic [7:0] FIRE = 8'h2C;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    shell_ctrl_if bus();

    shell_ctrl #(
        .FIRE_CODE      (FIRE),
        .SHELL_SPEED    (4),
        .EXPLODE_FRAMES (16),
        .HIT_HALF       (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic [9:0] tx, ty;
        logic [1:0] dir;
        logic [9:0] ox, oy;
        logic [9:0] ex, ey;
        logic       ea, eb, eh;
        logic [3:0] es;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int tx, ty, dir, ox, oy, ex, ey, ea, eb, eh, es);
        vec_t v;
        v.tx = 10'(tx); v.ty = 10'(ty); v.dir = 2'(dir);
        v.ox = 10'(ox); v.oy = 10'(oy);
        v.ex = 10'(ex); v.ey = 10'(ey);
        v.ea = 1'(ea);  v.eb = 1'(eb);  v.eh = 1'(eh); v.es = 4'(es);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic tick();
        @(negedge Clk) bus.frame_tick = 1'b1;
        @(negedge Clk) bus.frame_tick = 1'b0;
    endtask

    task automatic press();
        @(negedge Clk) bus.keycode = FIRE;
        @(negedge Clk) bus.keycode = 8'h00;
    endtask

    task automatic set_game(input int tx, ty, dir, ox, oy);
        bus.TankX = 10'(tx); bus.TankY = 10'(ty); bus.tank_dir = 2'(dir);
        bus.OppX = 10'(ox);  bus.OppY = 10'(oy);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.keycode    = 8'h00;
        set_game(0, 0, 0, 600, 400);

        vecs[0]  = mk(320, 240, 1, 600, 400, 324, 240, 1, 0, 0, 0);
        vecs[1]  = mk(320, 240, 3, 600, 400, 316, 240, 1, 0, 0, 0);
        vecs[2]  = mk(320, 240, 0, 600, 400, 320, 236, 1, 0, 0, 0);
        vecs[3]  = mk(320, 240, 2, 600, 400, 320, 244, 1, 0, 0, 0);
        vecs[4]  = mk(100,   3, 0, 600, 400, 100,   3, 0, 0, 0, 0);
        vecs[5]  = mk(100,   4, 0, 600, 400, 100,   0, 1, 0, 0, 0);
        vecs[6]  = mk(636, 100, 1, 600, 400, 636, 100, 0, 0, 0, 0);
        vecs[7]  = mk(635, 100, 1, 600, 400, 639, 100, 1, 0, 0, 0);
        vecs[8]  = mk(100, 476, 2, 600, 400, 100, 476, 0, 0, 0, 0);
        vecs[9]  = mk(100, 475, 2, 600, 400, 100, 479, 1, 0, 0, 0);
        vecs[10] = mk(100, 100, 1, 112, 108, 104, 100, 0, 1, 1, 1);
        vecs[11] = mk(100, 100, 1, 113, 100, 104, 100, 1, 0, 0, 0);
        vecs[12] = mk(200, 200, 3, 188, 192, 196, 200, 0, 1, 1, 1);
        vecs[13] = mk(637, 100, 1, 641, 100, 637, 100, 0, 0, 0, 0);
        vecs[14] = mk(300, 300, 2, 300, 300, 300, 304, 0, 1, 1, 1);

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("rst_x",     32'(bus.ShellX), 0);
        check("rst_y",     32'(bus.ShellY), 0);
        check("rst_act",   32'(bus.shell_active), 0);
        check("rst_boom",  32'(bus.exploding), 0);
        check("rst_hit",   32'(bus.hit), 0);
        check("rst_score", 32'(bus.score), 0);

        // Fire then one flight step from each vector's starting point.
        for (int i = 0; i < 15; i++) begin
            do_reset();
            set_game(vecs[i].tx, vecs[i].ty, vecs[i].dir, vecs[i].ox, vecs[i].oy);
            press();
            tick();
            tick();
            check($sformatf("v%0d_x", i),     32'(bus.ShellX), 32'(vecs[i].ex));
            check($sformatf("v%0d_y", i),     32'(bus.ShellY), 32'(vecs[i].ey));
            check($sformatf("v%0d_act", i),   32'(bus.shell_active), 32'(vecs[i].ea));
            check($sformatf("v%0d_boom", i),  32'(bus.exploding), 32'(vecs[i].eb));
            check($sformatf("v%0d_hit", i),   32'(bus.hit), 32'(vecs[i].eh));
            check($sformatf("v%0d_score", i), 32'(bus.score), 32'(vecs[i].es));
        end

        // Key held three clocks, tank moves mid-flight.
        do_reset();
        set_game(320, 240, 1, 600, 50);
        @(negedge Clk) bus.keycode = FIRE;
        repeat (3) @(negedge Clk);
        bus.keycode = 8'h00;
        tick();
        check("fire_act", 32'(bus.shell_active), 1);
        check("fire_x",   32'(bus.ShellX), 320);
        check("fire_y",   32'(bus.ShellY), 240);
        set_game(50, 60, 0, 600, 50);
        repeat (5) tick();
        check("fly5_x",   32'(bus.ShellX), 340);
        check("fly5_y",   32'(bus.ShellY), 240);

        // Left edge exit, then held key across many frames.
        do_reset();
        set_game(2, 100, 3, 600, 400);
        @(negedge Clk) bus.keycode = FIRE;
        tick();
        check("edge_fire_act", 32'(bus.shell_active), 1);
        tick();
        check("edge_act", 32'(bus.shell_active), 0);
        check("edge_x",   32'(bus.ShellX), 2);
        check("edge_hit", 32'(bus.hit), 0);
        begin
            int seen = 0;
            for (int t = 0; t < 200; t++) begin
                tick();
                if (bus.shell_active) seen++;
            end
            check("held_no_refire", 32'(seen), 0);
        end
        bus.keycode = 8'h00;

        // Hit on the third flight tick, explosion length, score saturation.
        do_reset();
        set_game(100, 100, 1, 120, 100);
        press();
        tick();
        tick();
        tick();
        check("pre_hit_x", 32'(bus.ShellX), 108);
        check("pre_hit",   32'(bus.hit), 0);
        tick();
        check("hit_pulse", 32'(bus.hit), 1);
        check("hit_x",     32'(bus.ShellX), 112);
        check("hit_boom",  32'(bus.exploding), 1);
        check("hit_score", 32'(bus.score), 1);
        @(negedge Clk);
        check("hit_one_clk", 32'(bus.hit), 0);
        repeat (15) tick();
        check("boom15",    32'(bus.exploding), 1);
        check("boom_hold", 32'(bus.ShellX), 112);
        tick();
        check("boom16",    32'(bus.exploding), 0);
        check("boom_idle", 32'(bus.shell_active), 0);
        for (int k = 0; k < 16; k++) begin
            press();
            repeat (4) tick();
            repeat (16) tick();
        end
        check("score_sat", 32'(bus.score), 15);

        // Reset while the explosion counter sits at 7.
        do_reset();
        press();
        repeat (4) tick();
        repeat (8) tick();
        check("mid_boom", 32'(bus.exploding), 1);
        do_reset();
        check("rb_x",     32'(bus.ShellX), 0);
        check("rb_y",     32'(bus.ShellY), 0);
        check("rb_act",   32'(bus.shell_active), 0);
        check("rb_boom",  32'(bus.exploding), 0);
        check("rb_hit",   32'(bus.hit), 0);
        check("rb_score", 32'(bus.score), 0);
        set_game(320, 240, 1, 600, 50);
        press();
        tick();
        check("rb_refire", 32'(bus.shell_active), 1);

        // Fire edge on the tick clock itself; a second fire mid-flight is dropped.
        do_reset();
        set_game(320, 240, 1, 600, 50);
        @(negedge Clk);
        bus.keycode = FIRE;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        bus.keycode = 8'h00;
        check("co_act", 32'(bus.shell_active), 1);
        check("co_x",   32'(bus.ShellX), 320);
        set_game(10, 10, 0, 600, 50);
        press();
        tick();
        check("co_ign_act", 32'(bus.shell_active), 1);
        check("co_ign_x",   32'(bus.ShellX), 324);
        check("co_ign_y",   32'(bus.ShellY), 240);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shell_ctrl.md
SHELL_CTRL -- requirements
Module: shell_ctrl

Interface
REQ-001 SHALL have parameter FIRE_CODE, default 8'h2C, USB keycode that fires the shell.
REQ-002 SHALL have parameter SHELL_SPEED, default 4, pixels moved per frame.
REQ-003 SHALL have parameter EXPLODE_FRAMES, default 16, frames the explosion is held.
REQ-004 SHALL have parameter HIT_HALF, default 8, half-width of the opponent hit box in pixels.
REQ-005 SHALL have ports: Clk  in  1  single system clock (50 MHz); all logic on rising edge.
REQ-006 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: frame_tick  in  1  one-Clk pulse per VGA frame.
REQ-008 SHALL have ports: keycode  in  8  current USB keycode.
REQ-009 SHALL have ports: TankX, TankY  in  10 each  firing tank centre.
REQ-010 SHALL have ports: tank_dir  in  2  firing tank facing: 0 up, 1 right, 2 down, 3 left.
REQ-011 SHALL have ports: OppX, OppY  in  10 each  opponent tank centre.
REQ-012 SHALL have ports: ShellX, ShellY  out  10 each  shell centre, to color mapper.
REQ-013 SHALL have ports: shell_active  out  1  high while state is FLY.
REQ-014 SHALL have ports: exploding  out  1  high while state is BOOM.
REQ-015 SHALL have ports: hit  out  1  one-Clk pulse on a scored hit.
REQ-016 SHALL have ports: score  out  4  hit count, saturating at 15.

Function
REQ-017 SHALL register every output.
REQ-018 SHALL implement states IDLE, FLY, BOOM; transitions occur only on a Clk edge where frame_tick=1, except for the hit pulse.
REQ-019 SHALL detect a fire edge when (keycode==FIRE_CODE) is 1 this Clk and was 0 the previous Clk; a held key fires once.
REQ-020 SHALL set fire_req on a fire edge and clear it on every frame_tick.
REQ-021 SHALL treat a fire edge coincident with frame_tick as pending at that tick.
REQ-022 IDLE + frame_tick + pending fire: ShellX/ShellY <= TankX/TankY; latch tank_dir; enter FLY; shell_active=1 on the following Clk.
REQ-023 In FLY/BOOM, pending fire SHALL be discarded; at most one shell exists.
REQ-024 FLY + frame_tick: compute next position = current ± SHELL_SPEED on the latched axis.
REQ-025 Out-of-bounds check: next position leaving 0..639 (X) or 0..479 (Y), including underflow (coord < SHELL_SPEED for up/left); on out-of-bounds, go IDLE with position unchanged and no hit.
REQ-026 Out-of-bounds SHALL take priority over a hit.
REQ-027 Hit check: |nextX-OppX| <= HIT_HALF and |nextY-OppY| <= HIT_HALF, using 11-bit unsigned absolute difference; on hit, load next position, enter BOOM, pulse hit for exactly one Clk, and increment score (saturating at 15).
REQ-028 Otherwise FLY SHALL update ShellX/ShellY to the next position.
REQ-029 On BOOM entry, load the frame counter with EXPLODE_FRAMES-1; decrement it each frame_tick; at 0 on a frame_tick, go IDLE; position is held throughout BOOM.
REQ-030 TankX/TankY/tank_dir changes during FLY SHALL not affect the shell.

Reset
REQ-031 Reset=1 at a Clk edge SHALL force state IDLE, ShellX=0, ShellY=0, shell_active=0, exploding=0, hit=0, score=0, fire_req=0, counter=0, edge history=0, regardless of state, including mid-FLY or mid-BOOM.
REQ-032 Reset SHALL take priority over frame_tick and fire.

Structure
REQ-033 Package tank_pkg SHALL hold shell_state_t (IDLE/FLY/BOOM), dir_t, and SCREEN_W=640, SCREEN_H=480.
REQ-034 Sub-module key_edge (registered level plus rising-edge pulse for one keycode compare) SHALL be instantiated once.

Verification
REQ-035 Test fire: Tank(320,240), dir=1, keycode 0x2C for 3 Clk, then tick -> active=1, Shell=(320,240); after 5 more ticks Shell=(340,240).
REQ-036 Test held key: keycode held 0x2C across 200 ticks after shell exits -> no second shell.
REQ-037 Test boundary: Shell fired at (2,100) dir=3 -> first tick: IDLE, ShellX=2, hit=0.
REQ-038 Test hit: Tank(100,100) dir=1, Opp(120,100) -> hit pulses 1 Clk on 3rd tick (next X=112), exploding=1 for 16 ticks, score=1; then 16 further hits -> score stays 15.
REQ-039 Test reset mid-BOOM at counter=7 -> all outputs 0 next Clk; fire edge plus tick -> FLY.
REQ-040 Test coincidence: fire edge on the same Clk as frame_tick in IDLE -> FLY; fire during FLY -> ignored.
